// File: rtl/cam_fb_streamer.sv
// -----------------------------------------------------------------------------
// cam_fb_streamer
//
// Purpose: Wishbone-controlled reader that streams a window of a captured
// frame buffer through a small prefetch FIFO. Software programs a start
// address and a pixel count, then sets start. The block fetches pixels from
// the frame buffer, wrapping at the end of the frame, and software pops them
// one at a time through the DATA register.
//
// Register map (word offset = i_wb_adr[5:2]):
//   0 CTRL   : bit0 start (self-clearing), bit2 irq_en, bit3 abort (self-clearing)
//   1 STATUS : {frame_done, busy, fifo_full, fifo_empty}; write 1 to bit3 clears
//   2 ADDR   : 17-bit start address (out-of-range writes store 0)
//   3 DATA   : read pops {1'b1, 19'b0, pixel}, or 0 when the FIFO is empty
//   4 COUNT  : 17-bit length (clamped to FB_DEPTH); reads pixels left while busy
//
// Configuration macro: CAM_FB_STREAMER_IRQ_EN
//   defined   : o_irq = registered irq_en & (frame_done | completion sticky)
//   undefined : o_irq tied 0, CTRL bit2 reads 0, no completion sticky
//
// Ports:
//   i_wb_clk, i_wb_rst          clock, asynchronous active-high reset
//   i_wb_adr/dat/sel/we/cyc/stb Wishbone slave request
//   o_wb_rdt, o_wb_ack          Wishbone response
//   o_fb_addr, i_fb_data        frame-buffer read port (data 1 cycle after addr)
//   i_frame_done                end-of-frame pulse from the capture stage
//   o_irq                       level interrupt
//
// FIFO_DEPTH must be a power of two and at least 2.
// -----------------------------------------------------------------------------
module cam_fb_streamer #(
    parameter int FB_DEPTH   = 76800,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        i_wb_clk,
    input  logic        i_wb_rst,
    input  logic [7:0]  i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_sel,
    input  logic        i_wb_we,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    output logic [16:0] o_fb_addr,
    input  logic [11:0] i_fb_data,
    input  logic        i_frame_done,
    output logic        o_irq
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [16:0]    LAST_ADDR = 17'(FB_DEPTH - 1);
    localparam logic [16:0]    DEPTH_17  = 17'(FB_DEPTH);
    localparam logic [31:0]    DEPTH_32  = 32'(FB_DEPTH);
    localparam logic [CNT_W:0] FIFO_CAP  = (CNT_W + 1)'(FIFO_DEPTH);

    localparam logic [3:0] REG_CTRL   = 4'd0;
    localparam logic [3:0] REG_STATUS = 4'd1;
    localparam logic [3:0] REG_ADDR   = 4'd2;
    localparam logic [3:0] REG_DATA   = 4'd3;
    localparam logic [3:0] REG_COUNT  = 4'd4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Bus decode
    logic [3:0] reg_idx;
    logic       wb_req, wb_wr, wb_rd_ack;
    logic       ctrl_wr, start_wr, abort_wr, status_clr;

    // Software-visible registers
    logic [16:0] addr_reg, count_reg;
    logic        frame_done;
    logic        irq_en_rd;

    // Transfer engine
    logic [16:0] fetch_addr, last_addr, issued_cnt, run_len, pix_left;
    logic        inflight;
    logic        issue, busy, run_start, run_done;
    logic [CNT_W:0] occupancy;

    // Prefetch FIFO
    logic [11:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] fifo_wp, fifo_rp;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty, fifo_full, push, pop, data_hit;

    logic [31:0] rdata;

    assign reg_idx    = i_wb_adr[5:2];
    assign wb_req     = i_wb_cyc & i_wb_stb;
    // Writes and pops take effect in the ack cycle, so each bus access acts once.
    assign wb_wr      = wb_req & i_wb_we & i_wb_sel & o_wb_ack;
    assign wb_rd_ack  = wb_req & ~i_wb_we & o_wb_ack;
    assign ctrl_wr    = wb_wr & (reg_idx == REG_CTRL);
    assign start_wr   = ctrl_wr & i_wb_dat[0];
    assign abort_wr   = ctrl_wr & i_wb_dat[3];
    assign status_clr = wb_wr & (reg_idx == REG_STATUS) & i_wb_dat[3];

    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == FIFO_CAP[CNT_W-1:0]);
    assign occupancy  = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight};

    // A fetched pixel arrives one cycle after its address; abort discards it.
    assign push = inflight & ~abort_wr;
    // The pop decision was made in the request cycle, when the head pixel was
    // captured into o_wb_rdt; nothing else can pop between request and ack.
    assign pop  = wb_rd_ack & data_hit;

    // The address port shows the issuing address, otherwise the last one issued.
    assign o_fb_addr = issue ? fetch_addr : last_addr;

    // ---------------------------------------------------------------- Wishbone
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, whatever the block order.
    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            o_wb_ack <= 1'b0;
            o_wb_rdt <= 32'd0;
            data_hit <= 1'b0;
        end else begin
            o_wb_ack <= wb_req & ~o_wb_ack;
            if (wb_req && !o_wb_ack) begin
                o_wb_rdt <= rdata;
                data_hit <= ~i_wb_we & (reg_idx == REG_DATA) & ~fifo_empty;
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        rdata = 32'd0;
        unique case (reg_idx)
            REG_CTRL:   rdata = {29'd0, irq_en_rd, 2'b00};
            REG_STATUS: rdata = {28'd0, frame_done, busy, fifo_full, fifo_empty};
            REG_ADDR:   rdata = {15'd0, addr_reg};
            REG_DATA:   rdata = fifo_empty ? 32'd0 : {1'b1, 19'd0, fifo_mem[fifo_rp]};
            REG_COUNT:  rdata = {15'd0, busy ? pix_left : count_reg};
            default:    rdata = 32'd0;
        endcase
    end

    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            addr_reg   <= 17'd0;
            count_reg  <= 17'd0;
            frame_done <= 1'b0;
        end else begin
            if (wb_wr && reg_idx == REG_ADDR)
                addr_reg <= (i_wb_dat >= DEPTH_32) ? 17'd0 : i_wb_dat[16:0];
            if (wb_wr && reg_idx == REG_COUNT)
                count_reg <= (i_wb_dat > DEPTH_32) ? DEPTH_17 : i_wb_dat[16:0];
            // A new frame event wins over a simultaneous clear.
            if (i_frame_done)
                frame_done <= 1'b1;
            else if (status_clr)
                frame_done <= 1'b0;
        end
    end

    // --------------------------------------------------------------------- FSM
    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (run_start) state_nxt = S_RUN;
            S_RUN:   if (issue && issued_cnt == run_len - 17'd1) state_nxt = S_DRAIN;
            S_DRAIN: if (run_done) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (abort_wr)
            state_nxt = S_IDLE;
    end

    always_comb begin
        busy      = (state != S_IDLE);
        run_start = (state == S_IDLE) & start_wr & ~abort_wr & (count_reg != 17'd0);
        run_done  = (state == S_DRAIN) & pop & (pix_left == 17'd1) & ~abort_wr;
        // The in-flight read still needs a FIFO slot, so it counts as occupied.
        issue     = (state == S_RUN) & ~abort_wr & (issued_cnt < run_len) &
                    (occupancy < FIFO_CAP);
    end

    // ----------------------------------------------------------- Fetch engine
    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            fetch_addr <= 17'd0;
            last_addr  <= 17'd0;
            issued_cnt <= 17'd0;
            run_len    <= 17'd0;
            pix_left   <= 17'd0;
            inflight   <= 1'b0;
        end else begin
            inflight <= issue;
            if (run_start) begin
                fetch_addr <= addr_reg;
                issued_cnt <= 17'd0;
                run_len    <= count_reg;
                pix_left   <= count_reg;
            end else begin
                if (issue) begin
                    last_addr  <= fetch_addr;
                    fetch_addr <= (fetch_addr == LAST_ADDR) ? 17'd0 : fetch_addr + 17'd1;
                    issued_cnt <= issued_cnt + 17'd1;
                end
                if (pop && busy)
                    pix_left <= pix_left - 17'd1;
            end
        end
    end

    // ------------------------------------------------------------------- FIFO
    // NOTE: the storage array has no reset; the pointers and count alone
    // define which entries are valid, so clearing the data buys nothing.
    always_ff @(posedge i_wb_clk) begin
        if (push)
            fifo_mem[fifo_wp] <= i_fb_data;
    end

    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            fifo_wp    <= '0;
            fifo_rp    <= '0;
            fifo_count <= '0;
        end else if (abort_wr) begin
            fifo_wp    <= '0;
            fifo_rp    <= '0;
            fifo_count <= '0;
        end else begin
            if (push)
                fifo_wp <= fifo_wp + 1'b1;
            if (pop)
                fifo_rp <= fifo_rp + 1'b1;
            unique case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // -------------------------------------------------------------- Interrupt
`ifdef CAM_FB_STREAMER_IRQ_EN
    logic irq_en, done_sticky;

    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            irq_en      <= 1'b0;
            done_sticky <= 1'b0;
            o_irq       <= 1'b0;
        end else begin
            if (ctrl_wr)
                irq_en <= i_wb_dat[2];
            if (run_done)
                done_sticky <= 1'b1;
            else if (status_clr)
                done_sticky <= 1'b0;
            o_irq <= irq_en & (frame_done | done_sticky);
        end
    end

    assign irq_en_rd = irq_en;
`else
    assign o_irq     = 1'b0;
    assign irq_en_rd = 1'b0;
`endif

    // Address bits outside the decoded word offset carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{i_wb_adr[7:6], i_wb_adr[1:0], run_done};

endmodule

// File: tb/tb_cam_fb_streamer.sv
// -----------------------------------------------------------------------------
// tb_cam_fb_streamer
//
// Directed bench for cam_fb_streamer. Each register read pushes its
// hand-computed expected word into a scoreboard queue; a monitor pops and
// compares whenever the DUT acks a read. A second monitor logs every new
// value on o_fb_addr so issue sequences can be checked. The frame buffer is
// modelled as a synchronous RAM whose pixel at address a is a[11:0] ^ 12'hA5C.
// -----------------------------------------------------------------------------
module tb_cam_fb_streamer;

    localparam logic [3:0] R_CTRL   = 4'd0;
    localparam logic [3:0] R_STATUS = 4'd1;
    localparam logic [3:0] R_ADDR   = 4'd2;
    localparam logic [3:0] R_DATA   = 4'd3;
    localparam logic [3:0] R_COUNT  = 4'd4;

`ifdef CAM_FB_STREAMER_IRQ_EN
    localparam logic IRQ_BUILD = 1'b1;
`else
    localparam logic IRQ_BUILD = 1'b0;
`endif

    logic        i_wb_clk = 1'b0;
    logic        i_wb_rst;
    logic [7:0]  i_wb_adr;
    logic [31:0] i_wb_dat;
    logic        i_wb_sel, i_wb_we, i_wb_cyc, i_wb_stb;
    logic [31:0] o_wb_rdt;
    logic        o_wb_ack;
    logic [16:0] o_fb_addr;
    logic [11:0] i_fb_data = 12'd0;
    logic        i_frame_done;
    logic        o_irq;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q [$];
    string       name_q [$];
    logic [31:0] mon_exp;
    string       mon_name;

    logic [16:0] addr_log [$];
    logic [16:0] addr_prev = 17'd0;

    logic [16:0] seq_wrap [4] = '{17'd76798, 17'd76799, 17'd0, 17'd1};

    cam_fb_streamer dut (
        .i_wb_clk     (i_wb_clk),
        .i_wb_rst     (i_wb_rst),
        .i_wb_adr     (i_wb_adr),
        .i_wb_dat     (i_wb_dat),
        .i_wb_sel     (i_wb_sel),
        .i_wb_we      (i_wb_we),
        .i_wb_cyc     (i_wb_cyc),
        .i_wb_stb     (i_wb_stb),
        .o_wb_rdt     (o_wb_rdt),
        .o_wb_ack     (o_wb_ack),
        .o_fb_addr    (o_fb_addr),
        .i_fb_data    (i_fb_data),
        .i_frame_done (i_frame_done),
        .o_irq        (o_irq)
    );

    always #5 i_wb_clk = ~i_wb_clk;

    // Synchronous frame-buffer RAM: data valid the cycle after the address.
    always @(posedge i_wb_clk) i_fb_data <= o_fb_addr[11:0] ^ 12'hA5C;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor and address logger.
    always @(negedge i_wb_clk) begin
        if (o_wb_ack && i_wb_cyc && i_wb_stb && !i_wb_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read_ack: got 0x%0h, expected no read response", o_wb_rdt);
            end else begin
                mon_exp  = exp_q.pop_front();
                mon_name = name_q.pop_front();
                check(mon_name, o_wb_rdt, mon_exp);
            end
        end
        if (o_fb_addr !== addr_prev) begin
            addr_log.push_back(o_fb_addr);
            addr_prev = o_fb_addr;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge i_wb_clk);
        #1;
    endtask

    // One Wishbone access; called at posedge+1, returns at posedge+1.
    task automatic wb_xfer(input logic we, input logic sel, input logic [3:0] idx,
                           input logic [31:0] dat, input string name);
        int n;
        i_wb_cyc = 1'b1;
        i_wb_stb = 1'b1;
        i_wb_we  = we;
        i_wb_sel = sel;
        i_wb_adr = {2'b00, idx, 2'b00};
        i_wb_dat = dat;
        n = 0;
        @(negedge i_wb_clk);
        while (!o_wb_ack && n < 8) begin
            @(negedge i_wb_clk);
            n++;
        end
        if (!o_wb_ack) begin
            checks++;
            errors++;
            $display("FAIL %s: got ack=0 after 8 cycles, expected ack=1", name);
            if (!we && exp_q.size() > 0) begin
                void'(exp_q.pop_back());
                void'(name_q.pop_back());
            end
        end
        @(posedge i_wb_clk);
        #1;
        i_wb_cyc = 1'b0;
        i_wb_stb = 1'b0;
        i_wb_we  = 1'b0;
    endtask

    task automatic wb_write(input logic [3:0] idx, input logic [31:0] dat);
        wb_xfer(1'b1, 1'b1, idx, dat, "write");
    endtask

    task automatic wb_read(input logic [3:0] idx, input logic [31:0] exp, input string name);
        exp_q.push_back(exp);
        name_q.push_back(name);
        wb_xfer(1'b0, 1'b1, idx, 32'd0, name);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected self-finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        i_wb_rst     = 1'b1;
        i_wb_adr     = 8'd0;
        i_wb_dat     = 32'd0;
        i_wb_sel     = 1'b0;
        i_wb_we      = 1'b0;
        i_wb_cyc     = 1'b0;
        i_wb_stb     = 1'b0;
        i_frame_done = 1'b0;
        idle(3);

        // Reset state
        check("rst_ack", o_wb_ack, 0);
        check("rst_rdt", o_wb_rdt, 0);
        check("rst_fb_addr", o_fb_addr, 0);
        check("rst_irq", o_irq, 0);
        i_wb_rst = 1'b0;
        idle(1);
        wb_read(R_CTRL,   32'h0, "rst_ctrl");
        wb_read(R_STATUS, 32'h1, "rst_status");
        wb_read(R_ADDR,   32'h0, "rst_addr");
        wb_read(R_COUNT,  32'h0, "rst_count");
        wb_read(R_DATA,   32'h0, "rst_data");

        // Basic 3-pixel transfer from address 100
        wb_write(R_ADDR, 32'd100);
        wb_write(R_COUNT, 32'd3);
        wb_write(R_CTRL, 32'h1);
        idle(6);
        wb_read(R_STATUS, 32'h4, "t1_status_busy");
        wb_read(R_COUNT,  32'd3, "t1_count_left");
        wb_read(R_DATA,   32'h8000_0A38, "t1_pix100");
        wb_read(R_DATA,   32'h8000_0A39, "t1_pix101");
        wb_read(R_DATA,   32'h8000_0A3A, "t1_pix102");
        wb_read(R_STATUS, 32'h1, "t1_status_idle");
        wb_read(R_DATA,   32'h0, "t1_data_empty");
        wb_read(R_COUNT,  32'd3, "t1_count_prog");
        wb_read(R_CTRL,   32'h0, "t1_ctrl_selfclear");

        // Address wrap at end of frame
        wb_write(R_ADDR, 32'd76798);
        wb_write(R_COUNT, 32'd4);
        addr_log.delete();
        wb_write(R_CTRL, 32'h1);
        idle(8);
        check("t2_issue_count", addr_log.size(), 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("t2_addr%0d", i), addr_log[i], seq_wrap[i]);
        wb_read(R_DATA,   32'h8000_01A2, "t2_pix76798");
        wb_read(R_DATA,   32'h8000_01A3, "t2_pix76799");
        wb_read(R_DATA,   32'h8000_0A5C, "t2_pix0");
        wb_read(R_DATA,   32'h8000_0A5D, "t2_pix1");
        wb_read(R_STATUS, 32'h1, "t2_status_idle");

        // Back-pressure: COUNT=10 with no pops stalls at four reads
        wb_write(R_ADDR, 32'd200);
        wb_write(R_COUNT, 32'd10);
        addr_log.delete();
        wb_write(R_CTRL, 32'h1);
        idle(12);
        check("t3_issue_count", addr_log.size(), 4);
        check("t3_addr_last", addr_log[3], 17'd203);
        wb_read(R_STATUS, 32'h6, "t3_status_full");
        wb_read(R_COUNT,  32'd10, "t3_count_left");
        wb_read(R_DATA,   32'h8000_0A94, "t3_pix200");
        idle(6);
        check("t3_issue_after_pop", addr_log.size(), 5);
        check("t3_addr_after_pop", addr_log[4], 17'd204);
        wb_read(R_COUNT,  32'd9, "t3_count_after_pop");
        wb_write(R_CTRL, 32'h8);
        wb_read(R_STATUS, 32'h1, "t3_status_abort");
        wb_read(R_COUNT,  32'd10, "t3_count_prog");

        // Abort with three entries buffered
        wb_write(R_ADDR, 32'd300);
        wb_write(R_COUNT, 32'd3);
        wb_write(R_CTRL, 32'h1);
        idle(8);
        wb_read(R_STATUS, 32'h4, "t4_status_three");
        wb_write(R_CTRL, 32'h8);
        wb_read(R_STATUS, 32'h1, "t4_status_after_abort");
        wb_read(R_DATA,   32'h0, "t4_data_after_abort");

        // frame_done set/clear, and set winning over a same-cycle clear
        i_frame_done = 1'b1;
        idle(1);
        i_frame_done = 1'b0;
        wb_read(R_STATUS, 32'h9, "t5_fd_set");
        wb_write(R_STATUS, 32'h8);
        wb_read(R_STATUS, 32'h1, "t5_fd_cleared");
        i_wb_cyc = 1'b1;
        i_wb_stb = 1'b1;
        i_wb_we  = 1'b1;
        i_wb_sel = 1'b1;
        i_wb_adr = {2'b00, R_STATUS, 2'b00};
        i_wb_dat = 32'h8;
        @(negedge i_wb_clk);
        @(negedge i_wb_clk);
        check("t5_clear_ack", o_wb_ack, 1);
        i_frame_done = 1'b1;
        @(posedge i_wb_clk);
        #1;
        i_wb_cyc     = 1'b0;
        i_wb_stb     = 1'b0;
        i_wb_we      = 1'b0;
        i_frame_done = 1'b0;
        wb_read(R_STATUS, 32'h9, "t5_fd_set_wins");
        wb_write(R_CTRL, 32'h4);
        idle(3);
        check("t5_irq_on", o_irq, IRQ_BUILD);
        wb_read(R_CTRL, {29'd0, IRQ_BUILD, 2'b00}, "t5_ctrl_irq_en");
        wb_write(R_STATUS, 32'h8);
        idle(3);
        check("t5_irq_off", o_irq, 0);
        wb_write(R_CTRL, 32'h0);

        // Register boundaries, byte-select, start with COUNT=0
        wb_write(R_COUNT, 32'd100000);
        wb_read(R_COUNT, 32'd76800, "t6_count_clamp");
        wb_write(R_ADDR, 32'd76800);
        wb_read(R_ADDR, 32'd0, "t6_addr_oob");
        wb_write(R_ADDR, 32'd76799);
        wb_read(R_ADDR, 32'd76799, "t6_addr_last");
        wb_xfer(1'b1, 1'b0, R_ADDR, 32'd5, "t6_sel0_write");
        wb_read(R_ADDR, 32'd76799, "t6_addr_sel0");
        wb_write(R_COUNT, 32'd0);
        wb_write(R_CTRL, 32'h1);
        idle(3);
        wb_read(R_STATUS, 32'h1, "t6_start_count0");
        wb_read(4'd7, 32'h0, "t6_unmapped");

        // Reset in the middle of a transfer
        wb_write(R_ADDR, 32'd0);
        wb_write(R_COUNT, 32'd10);
        wb_write(R_CTRL, 32'h1);
        idle(3);
        i_wb_rst = 1'b1;
        idle(2);
        check("t7_fb_addr_in_reset", o_fb_addr, 0);
        i_wb_rst = 1'b0;
        idle(6);
        wb_read(R_STATUS, 32'h1, "t7_status_after_rst");
        wb_read(R_COUNT,  32'h0, "t7_count_after_rst");
        wb_read(R_DATA,   32'h0, "t7_data_after_rst");

        idle(2);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cam_fb_streamer.md
CAM_FB_STREAMER -- requirements
Module: cam_fb_streamer

Interface
REQ-001 SHALL have parameter FB_DEPTH, default 76800, meaning pixels per stored frame (320x240).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning prefetch FIFO entries (power of 2).
REQ-003 SHALL have port i_wb_clk, input, 1, system clock; all logic on its rising edge.
REQ-004 SHALL have port i_wb_rst, input, 1, reset: asynchronous, active-high.
REQ-005 SHALL have ports i_wb_adr (input, 8), i_wb_dat (input, 32), i_wb_sel (input, 1), i_wb_we, i_wb_cyc and i_wb_stb (input, 1 each): Wishbone slave request.
REQ-006 SHALL have ports o_wb_rdt (output, 32) and o_wb_ack (output, 1): Wishbone response.
REQ-007 SHALL have port o_fb_addr, output, 17, frame-buffer read address.
REQ-008 SHALL have port i_fb_data, input, 12, RGB444 read data, valid exactly 1 cycle after o_fb_addr is presented.
REQ-009 SHALL have port i_frame_done, input, 1, single-cycle pulse from the capture stage at end of frame.
REQ-010 SHALL have port o_irq, output, 1, level interrupt.

Function
REQ-011 SHALL assert o_wb_ack for one cycle, one cycle after cyc&stb: ack <= cyc & stb & ~ack.
REQ-012 SHALL decode i_wb_adr[5:2]: 0 CTRL, 1 STATUS, 2 ADDR, 3 DATA, 4 COUNT; other offsets read 0 and ignore writes.
REQ-013 SHALL commit writes only when i_wb_sel=1, on the ack cycle.
REQ-014 CTRL SHALL hold bit0 start (self-clearing, reads 0), bit2 irq_en, bit3 abort (self-clearing, reads 0).
REQ-015 STATUS SHALL read {28'b0, frame_done, busy, fifo_full, fifo_empty}; writing 1 to bit3 clears frame_done.
REQ-016 frame_done SHALL set on i_frame_done; a set and a clear in the same cycle SHALL leave it set.
REQ-017 ADDR SHALL hold the 17-bit start address; a write value >= FB_DEPTH SHALL be stored as 0.
REQ-018 COUNT SHALL hold the 17-bit pixel length; a write value > FB_DEPTH SHALL be clamped to FB_DEPTH.
REQ-019 COUNT SHALL read back the pixels not yet popped while busy, and the programmed value otherwise.
REQ-020 SHALL implement FSM IDLE, RUN and DRAIN; busy = (state != IDLE).
REQ-021 IDLE -> RUN SHALL occur on a start write with COUNT != 0; a start with COUNT=0, or any start while busy, SHALL be ignored.
REQ-022 In RUN the block SHALL issue one read per cycle while issued < COUNT and fifo_count + inflight < FIFO_DEPTH.
REQ-023 Read data SHALL be pushed into the FIFO the cycle after issue.
REQ-024 The issue address SHALL increment by 1 and wrap from FB_DEPTH-1 to 0.
REQ-025 RUN -> DRAIN SHALL occur when the last read is issued; DRAIN -> IDLE SHALL occur when the final pixel is popped.
REQ-026 A DATA read SHALL return {1'b1, 19'b0, pixel} and pop the FIFO on the ack cycle; if the FIFO is empty it SHALL return 0 and not pop.
REQ-027 A push and a pop in the same cycle SHALL leave fifo_count unchanged.
REQ-028 Abort SHALL force IDLE, flush the FIFO and discard the in-flight read datum on the next cycle.
REQ-029 o_fb_addr SHALL hold its last value when no read is issued.

Reset
REQ-030 On i_wb_rst: state IDLE, FIFO empty, inflight 0, o_wb_ack 0, o_wb_rdt 0, o_fb_addr 0, o_irq 0, all registers 0.
REQ-031 Reset mid-transfer SHALL abandon the transfer with no further FIFO pushes after reset release.

Configuration
REQ-032 With macro CAM_FB_STREAMER_IRQ_EN defined, o_irq SHALL be registered as irq_en & (frame_done | DRAIN->IDLE completion sticky).
REQ-033 With CAM_FB_STREAMER_IRQ_EN defined, the completion sticky SHALL be cleared by writing 1 to STATUS bit3.
REQ-034 Without CAM_FB_STREAMER_IRQ_EN, o_irq SHALL be tied 0, CTRL bit2 SHALL read 0, and no completion sticky SHALL exist.

Verification
REQ-035 SHALL test: ADDR=100, COUNT=3, start, then 3 DATA reads -> 0x8000_0000|mem[100..102], busy falls after the third pop, and a fourth read returns 0.
REQ-036 SHALL test: ADDR=76798, COUNT=4 -> o_fb_addr sequence 76798, 76799, 0, 1.
REQ-037 SHALL test: COUNT=10 with no pops -> exactly 4 reads issued, fifo_full=1, no address advance until a pop.
REQ-038 SHALL test: abort while 3 entries are buffered -> next cycle busy=0 and fifo_empty=1, and a subsequent DATA read returns 0.
REQ-039 SHALL test: i_frame_done in the same cycle as a STATUS clear write -> STATUS bit3 reads 1; with IRQ_EN and irq_en=1, o_irq=1.
REQ-040 SHALL test: COUNT write of 100000 -> reads back 76800; start with COUNT=0 -> busy stays 0.
